// File: rtl/fwd_scoreboard_if.sv
// Bypass/interlock bus between the D stage and fwd_scoreboard.
// Packed [port][bit] arrays are bit-identical to the flat p*W +: W layout.
interface fwd_scoreboard_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int DEPTH = 3
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                      iss_valid;
  logic [AW-1:0]             iss_dst;
  logic [RW-1:0]             iss_rdy;
  logic                      freeze;
  logic                      flush;
  logic [DEPTH-1:0][DW-1:0]  stg_res;
  logic [NRD-1:0][AW-1:0]    rd_addr;
  logic [NRD-1:0][DW-1:0]    rd_rf;
  logic [NRD-1:0][DW-1:0]    rd_data;
  logic [NRD-1:0][SW-1:0]    rd_sel;
  logic                      stall;
  logic [31:0]               stall_cnt;

  modport master (
    output iss_valid, iss_dst, iss_rdy, freeze, flush, stg_res, rd_addr, rd_rf,
    input  rd_data, rd_sel, stall, stall_cnt
  );
  modport slave (
    input  iss_valid, iss_dst, iss_rdy, freeze, flush, stg_res, rd_addr, rd_rf,
    output rd_data, rd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand bypass + load-use interlock over DEPTH producer stages and NRD read ports.
// Optional: define FWD_STATS_EN to build the stall-cycle counter.

// Per-port lookup: youngest valid matching producer wins.
module fwd_port #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SW    = 2,
  parameter int RW    = 2
) (
  input  logic [AW-1:0]             addr,
  input  logic [DW-1:0]             rf,
  input  logic [DEPTH-1:0]          vld,
  input  logic [DEPTH-1:0][AW-1:0]  dst,
  input  logic [DEPTH-1:0][RW-1:0]  rdy,
  input  logic [DEPTH-1:0][DW-1:0]  res,
  output logic [DW-1:0]             data,
  output logic [SW-1:0]             sel,
  output logic                      pend
);
  always_comb begin
    data = rf;
    sel  = '0;
    pend = 1'b0;
    // Scan oldest to youngest so the youngest match is the one left standing.
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (vld[s] && (dst[s] == addr) && (addr != '0)) begin
        data = res[s];
        sel  = SW'(s + 1);
        pend = (s < int'(rdy[s]));
      end
    end
  end
endmodule

module fwd_scoreboard #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int DEPTH = 3
) (
  input logic         clk,
  input logic         reset,
  fwd_scoreboard_if.slave bus
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]          vld_pipe;
  logic [DEPTH-1:0][AW-1:0]  dst_pipe;
  logic [DEPTH-1:0][RW-1:0]  rdy_pipe;
  logic [NRD-1:0]            pend;
  logic [NRD-1:0][DW-1:0]    rd_data_w;
  logic [NRD-1:0][SW-1:0]    rd_sel_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dst_pipe <= '0;
      rdy_pipe <= '0;
    end else if (!bus.freeze) begin
      // A stalled or flushed D-stage instruction leaves a bubble behind.
      vld_pipe[0] <= bus.iss_valid & ~bus.stall & ~bus.flush & (bus.iss_dst != '0);
      dst_pipe[0] <= bus.iss_dst;
      rdy_pipe[0] <= bus.iss_rdy;
      for (int s = 1; s < DEPTH; s++) begin
        vld_pipe[s] <= vld_pipe[s-1] & ~(bus.flush && (s == 1));
        dst_pipe[s] <= dst_pipe[s-1];
        rdy_pipe[s] <= rdy_pipe[s-1];
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_port #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SW(SW), .RW(RW)) u_port (
      .addr (bus.rd_addr[p]),
      .rf   (bus.rd_rf[p]),
      .vld  (vld_pipe),
      .dst  (dst_pipe),
      .rdy  (rdy_pipe),
      .res  (bus.stg_res),
      .data (rd_data_w[p]),
      .sel  (rd_sel_w[p]),
      .pend (pend[p])
    );
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_sel  = rd_sel_w;
  assign bus.stall   = |pend;

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset)                         stall_cnt_q <= '0;
    else if (bus.stall && !bus.freeze) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expectations queued at drive time, popped at negedge.
module tb_fwd_scoreboard;
  localparam int DW = 32, AW = 5, NRD = 2, DEPTH = 3;
`ifdef FWD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.DW(DW), .AW(AW), .NRD(NRD), .DEPTH(DEPTH)) bus();
  fwd_scoreboard #(.DW(DW), .AW(AW), .NRD(NRD), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {string tag; int sig; logic [31:0] val;} exp_t;
  exp_t        expq[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0:       return 32'(bus.rd_sel[0]);
      1:       return bus.rd_data[0];
      2:       return 32'(bus.rd_sel[1]);
      3:       return bus.rd_data[1];
      4:       return 32'(bus.stall);
      default: return bus.stall_cnt;
    endcase
  endfunction

  task automatic exp_push(input string tag, input int sig, input logic [31:0] v);
    expq.push_back('{tag, sig, v});
  endtask

  task automatic exp_cnt_push(input string tag);
    exp_push(tag, 5, STATS ? exp_cnt : 32'd0);
  endtask

  // Check queued expectations mid-cycle, then advance one clock; issue/flush are one-shot.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
    @(posedge clk);
    #1;
    bus.iss_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] d, input logic r);
    bus.iss_valid = 1'b1;
    bus.iss_dst   = d;
    bus.iss_rdy   = 2'(r);
  endtask

  initial begin
    reset = 1'b1;
    bus.iss_valid = 1'b0; bus.iss_dst = '0; bus.iss_rdy = '0;
    bus.freeze = 1'b0; bus.flush = 1'b0;
    bus.stg_res[0] = 32'hABCD; bus.stg_res[1] = 32'h2222; bus.stg_res[2] = 32'h3333;
    bus.rd_addr[0] = 5'd5; bus.rd_addr[1] = 5'd3;
    bus.rd_rf[0] = 32'h11; bus.rd_rf[1] = 32'h22;
    @(posedge clk); #1;

    // reset state
    exp_push("rst_sel0", 0, 0); exp_push("rst_dat0", 1, 32'h11);
    exp_push("rst_sel1", 2, 0); exp_push("rst_dat1", 3, 32'h22);
    exp_push("rst_stall", 4, 0); exp_push("rst_cnt", 5, 0);
    cyc();
    reset = 1'b0;

    // ALU $8 walks E -> M -> W -> retired
    issue(5'd8, 1'b0); cyc();
    bus.rd_addr[0] = 5'd8;
    exp_push("alu_sel_e", 0, 1); exp_push("alu_dat_e", 1, 32'hABCD); exp_push("alu_stall", 4, 0);
    cyc();
    exp_push("alu_sel_m", 0, 2); exp_push("alu_dat_m", 1, 32'h2222); cyc();
    exp_push("alu_sel_w", 0, 3); exp_push("alu_dat_w", 1, 32'h3333); cyc();
    exp_push("alu_sel_ret", 0, 0); exp_push("alu_dat_ret", 1, 32'h11); cyc();

    // load-use: one stall, stalled $10 must not enter
    issue(5'd9, 1'b1); cyc();
    bus.rd_addr[0] = 5'd9;
    issue(5'd10, 1'b0);
    exp_push("ld_stall", 4, 1); exp_push("ld_sel_pend", 0, 1); exp_cnt_push("ld_cnt0");
    cyc(); exp_cnt++;
    bus.rd_addr[1] = 5'd10;
    exp_push("ld_unstall", 4, 0); exp_push("ld_sel_m", 0, 2); exp_push("ld_dat_m", 1, 32'h2222);
    exp_push("ld_noins_sel", 2, 0); exp_push("ld_noins_dat", 3, 32'h22); exp_cnt_push("ld_cnt1");
    cyc();
    exp_push("ld_sel_w", 0, 3); cyc();

    // youngest of two $4 producers; $0 never recorded
    bus.rd_addr[0] = 5'd5; bus.rd_addr[1] = 5'd3;
    cyc();
    issue(5'd4, 1'b0); cyc();
    issue(5'd11, 1'b0); cyc();
    issue(5'd4, 1'b0); cyc();
    bus.rd_addr[0] = 5'd4;
    issue(5'd0, 1'b0);
    exp_push("yng_sel", 0, 1); exp_push("yng_dat", 1, 32'hABCD); cyc();
    bus.rd_addr[1] = 5'd0; bus.rd_rf[1] = 32'h0;
    exp_push("yng_sel_m", 0, 2); exp_push("yng_dat_m", 1, 32'h2222);
    exp_push("r0_sel", 2, 0); exp_push("r0_dat", 3, 0);
    cyc();
    bus.rd_addr[0] = 5'd5; bus.rd_rf[1] = 32'h22; bus.rd_addr[1] = 5'd3;
    cyc(); cyc(); cyc();

    // freeze holds a pending load in stage 0
    issue(5'd7, 1'b1); cyc();
    bus.rd_addr[0] = 5'd7; bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(5'd12, 1'b0);
      exp_push("frz_stall", 4, 1); exp_push("frz_sel", 0, 1); exp_cnt_push("frz_cnt");
      cyc();
    end
    bus.freeze = 1'b0;
    exp_push("frz_rel_stall", 4, 1); exp_push("frz_rel_sel", 0, 1); cyc(); exp_cnt++;
    bus.rd_addr[1] = 5'd12;
    exp_push("frz_done_stall", 4, 0); exp_push("frz_done_sel", 0, 2);
    exp_push("frz_done_dat", 1, 32'h2222); exp_push("frz_no12", 2, 0); exp_cnt_push("frz_done_cnt");
    cyc();

    // flush drops stage 0 and the D-stage issue
    bus.rd_addr[0] = 5'd5; bus.rd_addr[1] = 5'd3;
    cyc(); cyc();
    issue(5'd6, 1'b0); cyc();
    bus.rd_addr[0] = 5'd6; bus.flush = 1'b1; issue(5'd13, 1'b0);
    exp_push("fl_sel_pre", 0, 1); cyc();
    bus.rd_addr[1] = 5'd13;
    exp_push("fl_sel0", 0, 0); exp_push("fl_dat0", 1, 32'h11); exp_push("fl_sel13", 2, 0);
    cyc();

    // reset mid-stall
    bus.rd_addr[1] = 5'd3;
    issue(5'd9, 1'b1); cyc();
    bus.rd_addr[0] = 5'd9;
    exp_push("rs_stall_pre", 4, 1); reset = 1'b1; cyc();
    exp_push("rs_stall", 4, 0); exp_push("rs_sel", 0, 0); exp_push("rs_dat", 1, 32'h11);
    exp_push("rs_cnt", 5, 0);
    cyc();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-bypass and interlock unit for the MIPS pipeline; generalises the per-operand forwarding mux to NRD read ports and DEPTH in-flight producer stages. It holds a shifting scoreboard of destination tags for instructions past decode, picks the youngest matching producer per read port, drives the forwarded operand, and raises a stall when the matching producer has no result yet (e.g. a load in E). It sits between the D-stage register-file read and the D/E pipeline register.

## Interface
- DW, 32, datapath width
- AW, 5, register-index width
- NRD, 2, read ports (rs, rt)
- DEPTH, 3, tracked producer stages (0=E, 1=M, 2=W)
- SW, $clog2(DEPTH+1), width of one select code
- clk  in  1  clock; one clock for the whole block
- reset  in  1  synchronous, active-high
- iss_valid  in  1  D-stage instruction writes a register
- iss_dst  in  AW  its destination index
- iss_rdy  in  $clog2(DEPTH)  first stage whose stg_res holds its result (0 for ALU ops, 1 for loads)
- freeze  in  1  global pipeline hold (cache miss); scoreboard does not shift
- flush  in  1  squash the D-stage instruction and stage 0
- stg_res  in  DEPTH*DW  result of each stage's pipeline register, stage s at [s*DW +: DW]
- rd_addr  in  NRD*AW  read indices
- rd_rf  in  NRD*DW  register-file values for those indices
- rd_data  out  NRD*DW  operand after bypass
- rd_sel  out  NRD*SW  0 = register file, s+1 = stage s
- stall  out  1  D-stage interlock
- stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Per-stage entry: valid, dst[AW], rdy[$clog2(DEPTH)]. Entry in stage s has data when s >= rdy.
- Advance (freeze=0): entry s moves to s+1; stage DEPTH-1 retires. Stage 0 loads {iss_valid & ~stall & ~flush & (iss_dst!=0), iss_dst, iss_rdy}; otherwise bubble (valid=0).
- flush (freeze=0): the D-stage instruction is not entered; the entry in stage 0 is dropped rather than moved to stage 1.
- freeze=1: all entries hold; flush and iss_* are ignored that cycle; stall still computed.
- Read port p: scan stages 0..DEPTH-1, first valid entry with dst==rd_addr[p] wins. rd_addr==0 never matches: rd_sel=0, rd_data=rd_rf (RF returns 0).
- Match with data: rd_sel=s+1, rd_data=stg_res[s]. No match: rd_sel=0, rd_data=rd_rf.
- Match without data: port pends; rd_sel/rd_data still point to that stage (value don't-care); stall=1.
- stall = OR of pending ports, combinational from state and rd_addr. Older matches never override a younger pending one.
- Index 0 destinations are never recorded.

## Timing
- rd_data, rd_sel, stall: combinational, same cycle as rd_addr/stg_res; no added latency.
- Scoreboard updates on rising clk; issue at cycle t sits in stage 0 during t+1.
- Load (iss_rdy=1) followed by dependent: stall for exactly 1 cycle, then forwards from stage 1.
- reset: all entries invalid, stall=0, rd_sel=0, rd_data=rd_rf, stall_cnt=0. Reset wins over freeze/flush; reset mid-stall clears the stall next cycle.
- Simultaneous stall and flush: bubble enters stage 0 and stage 0 is dropped; no double-insert.
- stall_cnt wraps from 0xFFFFFFFF to 0.

## Configuration
- FWD_STATS_EN defined: stall_cnt increments each cycle with stall=1 & freeze=0 & ~reset.
- Not defined: stall_cnt is constant 0, counter logic absent.

## Test plan
- Reset, then rd_addr={5,3}, rd_rf={0x11,0x22} -> rd_sel={0,0}, rd_data={0x11,0x22}, stall=0, stall_cnt=0.
- Issue ALU $8 (iss_rdy=0); next cycle rd_addr[0]=8, stg_res[0]=0xABCD -> rd_sel[0]=1, rd_data[0]=0xABCD, stall=0; one cycle later rd_sel[0]=2.
- Issue load $9 (iss_rdy=1); next cycle read $9 -> stall=1 one cycle, then rd_sel=2 with stg_res[1]; stall_cnt=1 with FWD_STATS_EN, 0 without.
- $4 in stages 0 and 2 with different values -> rd_sel=1 (youngest); read $0 with $0 issued -> rd_sel=0, rd_data=rd_rf.
- Load $7 in stage 0, freeze=1 for 3 cycles while reading $7 -> stall held 3 cycles, entry stays in stage 0, stall_cnt unchanged.
- Issue $6 then flush next cycle -> stage 0 entry dropped, read $6 gives rd_sel=0; reset asserted during a load stall -> stall=0 next cycle.
